hazard3_ahb_sram_wbuf: RTL

//  AHB-Lite slave bridging the single-port CPU master bus to a synchronous single-port SRAM.

---
 rtl/hazard3_ahb_sram_wbuf.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/hazard3_ahb_sram_wbuf.sv
// AHB-Lite slave to synchronous single-port SRAM: zero-wait OKAY transfers, 1-entry posted write buffer
// with read forwarding. Optional exclusive monitor enabled by defining HAZARD3_SRAM_EXCL_MONITOR_EN.
module hazard3_ahb_sram_wbuf #(
  parameter int unsigned W_DATA      = 32,
  parameter int unsigned W_SRAM_ADDR = 12
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   ahbls_hready,
  output logic                   ahbls_hready_resp,
  output logic                   ahbls_hresp,
  output logic                   ahbls_hexokay,
  input  logic [31:0]            ahbls_haddr,
  input  logic                   ahbls_hwrite,
  input  logic [1:0]             ahbls_htrans,
  input  logic [2:0]             ahbls_hsize,
  input  logic                   ahbls_hexcl,
  input  logic [W_DATA-1:0]      ahbls_hwdata,
  output logic [W_DATA-1:0]      ahbls_hrdata,

  output logic [W_SRAM_ADDR-1:0] sram_addr,
  output logic                   sram_ce,
  output logic                   sram_we,
  output logic [3:0]             sram_wbyteen,
  output logic [W_DATA-1:0]      sram_wdata,
  input  logic [W_DATA-1:0]      sram_rdata
);

  localparam int unsigned W_BYTES = W_DATA / 8;

  typedef enum logic [1:0] {WB_EMPTY, WB_PEND, WB_FULL} wb_state_t;
  typedef enum logic [1:0] {RS_OKAY, RS_ERR1, RS_ERR2} rs_state_t;

  wb_state_t              wb_state, wb_state_nxt;
  logic [W_SRAM_ADDR-1:0] wb_addr, wb_addr_nxt;
  logic [W_BYTES-1:0]     wb_mask, wb_mask_nxt;
  logic [W_DATA-1:0]      wb_data, wb_data_nxt;
  rs_state_t              rs_state, rs_state_nxt;

  logic                   dph_read;
  logic                   dph_hit;

  logic [W_SRAM_ADDR-1:0] aph_addr;
  logic [W_BYTES-1:0]     aph_mask;
  logic [W_BYTES-1:0]     wr_mask;
  logic                   aph_valid;
  logic                   aph_err;
  logic                   aph_exokay;
  logic                   read_acc;
  logic                   write_acc;
  logic                   err_acc;
  logic                   retire;

  logic unused_bits;
  assign unused_bits = ^{ahbls_htrans[0], ahbls_haddr[31:W_SRAM_ADDR+2]};

  // Address-phase decode: alignment check and byte lane mask
  assign aph_addr  = ahbls_haddr[W_SRAM_ADDR+1:2];
  assign aph_valid = !rst && ahbls_hready && ahbls_htrans[1];

  always_comb begin
    aph_err  = 1'b0;
    aph_mask = '0;
    case (ahbls_hsize)
      3'd0: aph_mask = 4'b0001 << ahbls_haddr[1:0];
      3'd1: begin
        aph_mask = 4'b0011 << ahbls_haddr[1:0];
        aph_err  = ahbls_haddr[0];
      end
      3'd2: begin
        aph_mask = 4'b1111;
        aph_err  = |ahbls_haddr[1:0];
      end
      default: aph_err = 1'b1;
    endcase
  end

  assign read_acc  = aph_valid && !aph_err && !ahbls_hwrite;
  assign write_acc = aph_valid && !aph_err &&  ahbls_hwrite;
  assign err_acc   = aph_valid &&  aph_err;

  // A PEND entry whose data phase completes this cycle can be written straight through from hwdata
  assign retire = !rst && !read_acc &&
                  (wb_state == WB_FULL || (wb_state == WB_PEND && ahbls_hready));

`ifdef HAZARD3_SRAM_EXCL_MONITOR_EN
  logic                   resv_valid, resv_valid_nxt;
  logic [W_SRAM_ADDR-1:0] resv_addr, resv_addr_nxt;
  logic                   resv_hit;

  assign resv_hit = resv_valid && resv_addr == aph_addr;

  always_comb begin
    resv_valid_nxt = resv_valid;
    resv_addr_nxt  = resv_addr;
    aph_exokay     = 1'b0;
    wr_mask        = aph_mask;
    if (read_acc && ahbls_hexcl) begin
      resv_valid_nxt = 1'b1;
      resv_addr_nxt  = aph_addr;
      aph_exokay     = 1'b1;
    end else if (write_acc) begin
      if (ahbls_hexcl) begin
        aph_exokay     = resv_hit;
        resv_valid_nxt = 1'b0;
        if (!resv_hit)
          wr_mask = '0;
      end else if (resv_hit) begin
        resv_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else begin
      resv_valid <= resv_valid_nxt;
      resv_addr  <= resv_addr_nxt;
    end
  end
`else
  // Without a monitor every store-conditional must fail, so its bytes are dropped
  assign aph_exokay = 1'b0;
  assign wr_mask    = ahbls_hexcl ? '0 : aph_mask;
`endif

  // Write buffer: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_state <= WB_EMPTY;
      wb_addr  <= '0;
      wb_mask  <= '0;
      wb_data  <= '0;
    end else begin
      wb_state <= wb_state_nxt;
      wb_addr  <= wb_addr_nxt;
      wb_mask  <= wb_mask_nxt;
      wb_data  <= wb_data_nxt;
    end
  end

  // Write buffer: next state
  always_comb begin
    wb_state_nxt = wb_state;
    wb_addr_nxt  = wb_addr;
    wb_mask_nxt  = wb_mask;
    wb_data_nxt  = wb_data;
    if (write_acc) begin
      wb_state_nxt = WB_PEND;
      wb_addr_nxt  = aph_addr;
      wb_mask_nxt  = wr_mask;
    end else if (retire) begin
      wb_state_nxt = WB_EMPTY;
    end else if (wb_state == WB_PEND && ahbls_hready) begin
      wb_state_nxt = WB_FULL;
      wb_data_nxt  = ahbls_hwdata;
    end
  end

  // Write buffer: SRAM port, accepted read has priority over retirement
  always_comb begin
    sram_ce      = 1'b0;
    sram_we      = 1'b0;
    sram_addr    = wb_addr;
    sram_wbyteen = '0;
    sram_wdata   = (wb_state == WB_FULL) ? wb_data : ahbls_hwdata;
    if (read_acc) begin
      sram_ce   = 1'b1;
      sram_addr = aph_addr;
    end else if (retire) begin
      sram_ce      = 1'b1;
      sram_we      = 1'b1;
      sram_wbyteen = wb_mask;
    end
  end

  // Data-phase tracking for reads, forwarding and exclusive status
  always_ff @(posedge clk) begin
    if (rst) begin
      dph_read      <= 1'b0;
      dph_hit       <= 1'b0;
      ahbls_hexokay <= 1'b0;
    end else if (ahbls_hready) begin
      dph_read      <= read_acc;
      dph_hit       <= read_acc && wb_state != WB_EMPTY && wb_addr == aph_addr;
      ahbls_hexokay <= aph_exokay;
    end
  end

  always_comb begin
    ahbls_hrdata = '0;
    if (dph_read) begin
      for (int i = 0; i < int'(W_BYTES); i++)
        ahbls_hrdata[8*i +: 8] = (dph_hit && wb_mask[i]) ? wb_data[8*i +: 8] : sram_rdata[8*i +: 8];
    end
  end

  // Error response: state register
  always_ff @(posedge clk) begin
    if (rst)
      rs_state <= RS_OKAY;
    else
      rs_state <= rs_state_nxt;
  end

  // Error response: next state
  always_comb begin
    rs_state_nxt = rs_state;
    case (rs_state)
      RS_OKAY: if (err_acc) rs_state_nxt = RS_ERR1;
      RS_ERR1: rs_state_nxt = RS_ERR2;
      RS_ERR2: rs_state_nxt = err_acc ? RS_ERR1 : RS_OKAY;
      default: rs_state_nxt = RS_OKAY;
    endcase
  end

  // Error response: outputs decoded from the state register only
  always_comb begin
    ahbls_hready_resp = (rs_state != RS_ERR1);
    ahbls_hresp       = (rs_state != RS_OKAY);
  end

endmodule
